// File: rtl/mat_frame_pkg.sv
// Shared constants, status codes and FSM state type for the matrix frame parser.
// Imported by mat_frame_parser and byte_timeout.
package mat_frame_pkg;
    localparam logic [7:0] SYNC_BYTE  = 8'hFF;
    localparam logic [7:0] SEL_A      = 8'h00;
    localparam logic [7:0] SEL_B      = 8'h01;
    localparam logic [7:0] ST_OK_A    = 8'hA0;
    localparam logic [7:0] ST_OK_B    = 8'hA1;
    localparam logic [7:0] ST_CSUM    = 8'hE0;
    localparam logic [7:0] ST_JOB     = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT = 8'hE2;
    localparam logic [7:0] ST_SEL     = 8'hE3;

    typedef enum logic [2:0] {
        S_SYNC,
        S_SEL,
        S_JOB,
        S_ELEM,
        S_CSUM
    } state_e;

    // All rejection statuses share the 0xE_ high nibble.
    function automatic logic is_err(input logic [7:0] st);
        return st[7:4] == 4'hE;
    endfunction
endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle timer: counts idle cycles while enabled, cleared by a byte.
// Ports: clk, rst_n, clr (byte accepted), en (frame open), expired (abort pulse).
module byte_timeout
    import mat_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_200_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds (idle cycles so far - 1); a byte in the same cycle wins.
    always_comb begin
        expired = en && !clr && (cnt_q == LAST);
        cnt_d   = cnt_q + 1'b1;
        if (clr || !en || expired) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mat_frame_parser.sv
// Checksummed A/B matrix frame parser with atomic pair commit and status replies.
// Ports: rx_* byte input, tx_* status output, mat_a/mat_b/job_id/mats_valid, err_count.
module mat_frame_parser
    import mat_frame_pkg::*;
#(
    parameter int unsigned DIM         = 2,
    parameter int unsigned TIMEOUT_CYC = 1_200_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [DIM*DIM*8-1:0]    mat_a,
    output logic [DIM*DIM*8-1:0]    mat_b,
    output logic [7:0]              job_id,
    output logic                    mats_valid,
    output logic [7:0]              err_count
);
    localparam int unsigned N  = DIM * DIM;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned W  = N * 8;

    state_e         state_q, state_d;
    logic           sel_b_q, sel_b_d;
    logic [7:0]     job_q, job_d;
    logic [7:0]     xor_q, xor_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]   hold_a_q, hold_a_d;
    logic [7:0]     pend_q, pend_d;
    logic           a_loaded_q, a_loaded_d;
    logic [W-1:0]   mat_a_q, mat_a_d;
    logic [W-1:0]   mat_b_q, mat_b_d;
    logic [7:0]     job_id_q, job_id_d;
    logic           mats_valid_q, mats_valid_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     err_q, err_d;

    logic           expired;
    logic           st_vld;
    logic [7:0]     st_byte;
    logic           drop;
    logic [1:0]     err_inc;
    logic [8:0]     err_sum;

    byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rx_valid),
        .en      (state_q != S_SYNC),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        sel_b_d      = sel_b_q;
        job_d        = job_q;
        xor_d        = xor_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        hold_a_d     = hold_a_q;
        pend_d       = pend_q;
        a_loaded_d   = a_loaded_q;
        mat_a_d      = mat_a_q;
        mat_b_d      = mat_b_q;
        job_id_d     = job_id_q;
        mats_valid_d = 1'b0;
        st_vld       = 1'b0;
        st_byte      = 8'h00;

        if (expired) begin
            state_d = S_SYNC;
            st_vld  = 1'b1;
            st_byte = ST_TIMEOUT;
        end else if (rx_valid) begin
            unique case (state_q)
                S_SYNC: begin
                    if (rx_data == SYNC_BYTE) state_d = S_SEL;
                end
                S_SEL: begin
                    if (rx_data == SEL_A || rx_data == SEL_B) begin
                        sel_b_d = rx_data[0];
                        state_d = S_JOB;
                    end else begin
                        state_d = S_SYNC;
                        st_vld  = 1'b1;
                        st_byte = ST_SEL;
                    end
                end
                S_JOB: begin
                    job_d   = rx_data;
                    xor_d   = rx_data;
                    idx_d   = '0;
                    state_d = S_ELEM;
                end
                S_ELEM: begin
                    shadow_d[int'(idx_q)*8 +: 8] = rx_data;
                    xor_d = xor_q ^ rx_data;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(N - 1)) state_d = S_CSUM;
                end
                S_CSUM: begin
                    state_d = S_SYNC;
                    st_vld  = 1'b1;
                    if (rx_data != xor_q) begin
                        st_byte = ST_CSUM;
                    end else if (!sel_b_q) begin
                        hold_a_d   = shadow_q;
                        pend_d     = job_q;
                        a_loaded_d = 1'b1;
                        st_byte    = ST_OK_A;
                    end else if (!a_loaded_q || job_q != pend_q) begin
                        st_byte = ST_JOB;
                    end else begin
                        mat_a_d      = hold_a_q;
                        mat_b_d      = shadow_q;
                        job_id_d     = job_q;
                        mats_valid_d = 1'b1;
                        a_loaded_d   = 1'b0;
                        st_byte      = ST_OK_B;
                    end
                end
                default: state_d = S_SYNC;
            endcase
        end

        // One-deep status buffer; a busy, non-draining buffer drops the new entry.
        drop       = st_vld && tx_valid_q && !tx_ready;
        tx_valid_d = tx_valid_q && !tx_ready;
        tx_data_d  = tx_data_q;
        if (st_vld && !drop) begin
            tx_valid_d = 1'b1;
            tx_data_d  = st_byte;
        end

        err_inc = {1'b0, st_vld && is_err(st_byte)} + {1'b0, drop};
        err_sum = {1'b0, err_q} + {7'd0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_SYNC;
            sel_b_q      <= 1'b0;
            job_q        <= '0;
            xor_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            hold_a_q     <= '0;
            pend_q       <= '0;
            a_loaded_q   <= 1'b0;
            mat_a_q      <= '0;
            mat_b_q      <= '0;
            job_id_q     <= '0;
            mats_valid_q <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_b_q      <= sel_b_d;
            job_q        <= job_d;
            xor_q        <= xor_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            hold_a_q     <= hold_a_d;
            pend_q       <= pend_d;
            a_loaded_q   <= a_loaded_d;
            mat_a_q      <= mat_a_d;
            mat_b_q      <= mat_b_d;
            job_id_q     <= job_id_d;
            mats_valid_q <= mats_valid_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            err_q        <= err_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign mat_a      = mat_a_q;
    assign mat_b      = mat_b_q;
    assign job_id     = job_id_q;
    assign mats_valid = mats_valid_q;
    assign err_count  = err_q;
endmodule
